// File: rtl/mb8_pkg.sv
// Shared types for the radix-8 Booth multiplier.
// Digit encoding and recoding helper.
package mb8_pkg;

  localparam int WIDTH   = 8;
  localparam int NDIGITS = 3;
  localparam int PP_W    = 12;
  localparam int WIN_W   = 4;

  typedef enum logic [2:0] {
    MAG_ZERO,
    MAG_ONE,
    MAG_TWO,
    MAG_THREE,
    MAG_FOUR
  } booth_mag_e;

  typedef struct packed {
    logic       neg;
    booth_mag_e mag;
  } booth_dig_t;

  // w = {y[3i+2], y[3i+1], y[3i], y[3i-1]}
  function automatic booth_dig_t booth_encode(
    input logic [WIN_W-1:0] w
  );
    booth_dig_t d;
    d.neg = w[3] & ~(&w);
    unique case (w)
      4'b0000, 4'b1111: d.mag = MAG_ZERO;
      4'b0001, 4'b0010,
      4'b1101, 4'b1110: d.mag = MAG_ONE;
      4'b0011, 4'b0100,
      4'b1011, 4'b1100: d.mag = MAG_TWO;
      4'b0101, 4'b0110,
      4'b1001, 4'b1010: d.mag = MAG_THREE;
      4'b0111, 4'b1000: d.mag = MAG_FOUR;
      default:          d.mag = MAG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mb8_booth_sel.sv
// Booth partial-product selector for one digit.
// Negative rows are one's complement; +1 goes out as neg.
module mb8_booth_sel
  import mb8_pkg::*;
(
  input  logic [WIN_W-1:0] win,
  input  logic [WIDTH-1:0] mx,
  input  logic [WIDTH+1:0] mx3,
  output logic [PP_W-1:0]  pp,
  output logic             neg
);

  booth_dig_t       dig;
  logic [PP_W-1:0]  mag_v;

  always_comb begin
    dig   = booth_encode(win);
    mag_v = '0;
    unique case (dig.mag)
      MAG_ONE:   mag_v = PP_W'(mx);
      MAG_TWO:   mag_v = PP_W'({mx, 1'b0});
      MAG_THREE: mag_v = PP_W'(mx3);
      MAG_FOUR:  mag_v = PP_W'({mx, 2'b00});
      default:   mag_v = '0;
    endcase
    pp  = dig.neg ? ~mag_v : mag_v;
    neg = dig.neg;
  end

endmodule

// File: rtl/mb8_top.sv
// 3-stage pipelined 8x8 unsigned multiplier,
// radix-8 Booth recoding of my.
module mb8_top #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   mx,
  input  logic [WIDTH-1:0]   my,
  output logic [WIDTH-1:0]   mx2,
  output logic [WIDTH-1:0]   my2,
  output logic [2*WIDTH-1:0] product
);
  import mb8_pkg::*;

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0]              mx2_q, mx2_d;
  logic [WIDTH-1:0]              my2_q, my2_d;
  logic [NDIGITS-1:0][PP_W-1:0]  pp_q, pp_d;
  logic [NDIGITS-1:0]            cin_q, cin_d;
  logic [PW-1:0]                 prod_q, prod_d;

  logic [WIDTH+1:0] mx3;
  logic [WIDTH+1:0] ybits;

  assign mx3   = {2'b00, mx2_q} + {1'b0, mx2_q, 1'b0};
  assign ybits = {1'b0, my2_q, 1'b0};

  for (genvar i = 0; i < NDIGITS; i++) begin : g_sel
    mb8_booth_sel u_sel (
      .win (ybits[3*i+3:3*i]),
      .mx  (mx2_q),
      .mx3 (mx3),
      .pp  (pp_d[i]),
      .neg (cin_d[i])
    );
  end

  // Top digit is never negative, so the wrapped sum is exact.
  always_comb begin
    logic [PW-1:0] acc;
    logic [PW-1:0] row;
    logic [PW-1:0] cin;
    mx2_d = mx;
    my2_d = my;
    acc   = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      row = {{(PW-PP_W){pp_q[i][PP_W-1]}}, pp_q[i]};
      cin = PW'(cin_q[i]);
      acc = acc + (row << (3 * i)) + (cin << (3 * i));
    end
    prod_d = acc;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mx2_q  <= '0;
      my2_q  <= '0;
      pp_q   <= '0;
      cin_q  <= '0;
      prod_q <= '0;
    end else begin
      mx2_q  <= mx2_d;
      my2_q  <= my2_d;
      pp_q   <= pp_d;
      cin_q  <= cin_d;
      prod_q <= prod_d;
    end
  end

  assign mx2     = mx2_q;
  assign my2     = my2_q;
  assign product = prod_q;

endmodule

// File: tb/tb_mb8_top.sv
// Self-checking bench for mb8_top: directed corners,
// random streaming and mid-stream reset against a delay-line model.
module tb_mb8_top;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  mx  = 8'h00;
  logic [7:0]  my  = 8'h00;
  logic [7:0]  mx2;
  logic [7:0]  my2;
  logic [15:0] product;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] hist [3] = '{default: 16'h0};
  logic [7:0]  xh = 8'h00;
  logic [7:0]  yh = 8'h00;

  always #5 CLK = ~CLK;

  mb8_top #(.WIDTH(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .mx      (mx),
    .my      (my),
    .mx2     (mx2),
    .my2     (my2),
    .product (product)
  );

  // Reference: arithmetic product of each sampled pair, seen 2 edges later.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hist <= '{default: 16'h0};
      xh   <= 8'h00;
      yh   <= 8'h00;
    end else begin
      hist[0] <= 16'(mx) * 16'(my);
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      xh      <= mx;
      yh      <= my;
    end
  end

  task automatic test_reset();
    RST = 1'b0;
    mx  = 8'hFF;
    my  = 8'hFF;
    repeat (3) begin
      @(negedge CLK);
      vectors += 3;
      if (product !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_product: got %h want 0000", product);
      end
      if (mx2 !== 8'h0) begin
        miscompares++;
        $display("FAIL reset_mx2: got %h want 00", mx2);
      end
      if (my2 !== 8'h0) begin
        miscompares++;
        $display("FAIL reset_my2: got %h want 00", my2);
      end
    end
    RST = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLK);
      vectors++;
      if (c < 3) begin
        if (product !== 16'h0) begin
          miscompares++;
          $display("FAIL release_zero%0d: got %h want 0000",
                   c, product);
        end
      end else if (product !== 16'hFE01) begin
        miscompares++;
        $display("FAIL release_first: got %h want fe01", product);
      end
    end
  endtask

  task automatic test_corners();
    logic [7:0]  xs [4];
    logic [7:0]  ys [4];
    logic [15:0] ex [4];
    xs = '{8'h00, 8'h01, 8'hFF, 8'h80};
    ys = '{8'hA5, 8'hFF, 8'hFF, 8'h80};
    ex = '{16'h0000, 16'h00FF, 16'hFE01, 16'h4000};
    for (int c = 0; c < 7; c++) begin
      if (c >= 1 && c <= 4) begin
        vectors += 2;
        if (mx2 !== xs[c-1] || my2 !== ys[c-1]) begin
          miscompares++;
          $display("FAIL corner_regs%0d: got %h/%h want %h/%h",
                   c - 1, mx2, my2, xs[c-1], ys[c-1]);
        end
      end
      if (c >= 3) begin
        vectors++;
        if (product !== ex[c-3]) begin
          miscompares++;
          $display("FAIL corner%0d: got %h want %h",
                   c - 3, product, ex[c-3]);
        end
      end
      mx = (c < 4) ? xs[c] : 8'h00;
      my = (c < 4) ? ys[c] : 8'h00;
      @(negedge CLK);
    end
  endtask

  task automatic test_booth_digits();
    logic [7:0]  xs [2];
    logic [7:0]  ys [2];
    logic [15:0] ex [2];
    xs = '{8'h3C, 8'h7F};
    ys = '{8'h5A, 8'hB6};
    ex = '{16'h1518, 16'h5A4A};
    for (int c = 0; c < 5; c++) begin
      if (c >= 3) begin
        vectors++;
        if (product !== ex[c-3]) begin
          miscompares++;
          $display("FAIL booth%0d: got %h want %h",
                   c - 3, product, ex[c-3]);
        end
      end
      mx = (c < 2) ? xs[c] : 8'h00;
      my = (c < 2) ? ys[c] : 8'h00;
      @(negedge CLK);
    end
  endtask

  task automatic test_stream(input int n);
    for (int k = 0; k < n; k++) begin
      mx = 8'($urandom);
      my = 8'($urandom);
      @(negedge CLK);
      vectors += 2;
      if (product !== hist[2]) begin
        miscompares++;
        $display("FAIL stream_product@%0d: got %h want %h",
                 k, product, hist[2]);
      end
      if (mx2 !== xh || my2 !== yh) begin
        miscompares++;
        $display("FAIL stream_regs@%0d: got %h/%h want %h/%h",
                 k, mx2, my2, xh, yh);
      end
    end
  endtask

  task automatic test_midstream_reset();
    test_stream(20);
    RST = 1'b0;
    #1;
    vectors++;
    if (product !== 16'h0 || mx2 !== 8'h0 || my2 !== 8'h0) begin
      miscompares++;
      $display("FAIL async_clear: got %h %h/%h want 0000 00/00",
               product, mx2, my2);
    end
    @(negedge CLK);
    RST = 1'b1;
    for (int k = 0; k < 25; k++) begin
      mx = 8'($urandom);
      my = 8'($urandom);
      @(negedge CLK);
      if (k < 2) begin
        vectors++;
        if (product !== 16'h0) begin
          miscompares++;
          $display("FAIL post_reset_zero%0d: got %h want 0000",
                   k, product);
        end
      end
      vectors++;
      if (product !== hist[2]) begin
        miscompares++;
        $display("FAIL post_reset@%0d: got %h want %h",
                 k, product, hist[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_booth_digits();
    test_stream(10000);
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
